// File: rtl/fp_max_reduce.sv
// Streaming per-frame maximum of floating-point words using sign-magnitude ordering.
// Reports the winning word, its position, the frame length and whether the MaxLen cap closed the frame.
module fp_max_reduce #(
  parameter int Bits   = 32,
  parameter int MaxLen = 256,
  localparam int IW    = $clog2(MaxLen)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [Bits-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Bits-1:0] out_max,
  output logic [IW-1:0]   out_idx,
  output logic [IW:0]     out_count,
  output logic            out_trunc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [IW:0] MaxCnt = (IW+1)'(MaxLen);

  logic [1:0]      state_reg, state_next;
  logic [Bits-1:0] max_reg, max_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [IW:0]     count_reg, count_next;
  logic            trunc_reg, trunc_next;
  logic            ready_reg, ready_next;

  logic            in_fire;
  logic            s_wins;
  logic [IW:0]     count_inc;
  logic            s_sign, r_sign;
  logic [Bits-2:0] s_mag, r_mag;

  assign in_fire   = in_valid && ready_reg;
  assign count_inc = count_reg + 1'b1;

  assign s_sign = in_data[Bits-1];
  assign r_sign = max_reg[Bits-1];
  assign s_mag  = in_data[Bits-2:0];
  assign r_mag  = max_reg[Bits-2:0];

  // Ties: an equal positive keeps the earlier sample, an equal negative takes the newer one.
  always_comb begin
    if (s_sign != r_sign) begin
      s_wins = !s_sign;
    end else if (!s_sign) begin
      s_wins = s_mag > r_mag;
    end else begin
      s_wins = s_mag <= r_mag;
    end
  end

  always_comb begin
    state_next = state_reg;
    max_next   = max_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    trunc_next = trunc_reg;
    case (state_reg)
      IDLE: begin
        if (in_fire) begin
          max_next   = in_data;
          idx_next   = '0;
          count_next = {{IW{1'b0}}, 1'b1};
          if (in_last || MaxCnt == {{IW{1'b0}}, 1'b1}) begin
            state_next = DONE;
            trunc_next = !in_last;
          end else begin
            state_next = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_fire) begin
          if (s_wins) begin
            max_next = in_data;
            idx_next = count_reg[IW-1:0];
          end
          count_next = count_inc;
          if (in_last || count_inc == MaxCnt) begin
            state_next = DONE;
            trunc_next = !in_last;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          trunc_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered ready keeps in_ready low during reset and rises on the first clock afterwards.
  assign ready_next = (state_next != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      max_reg   <= '0;
      idx_reg   <= '0;
      count_reg <= '0;
      trunc_reg <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      max_reg   <= max_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
      trunc_reg <= trunc_next;
      ready_reg <= ready_next;
    end
  end

  assign in_ready  = ready_reg;
  assign out_valid = (state_reg == DONE);
  assign out_max   = max_reg;
  assign out_idx   = idx_reg;
  assign out_count = count_reg;
  assign out_trunc = trunc_reg;

endmodule

// File: tb/tb_fp_max_reduce.sv
// Directed, table-driven bench for fp_max_reduce at Bits=32, MaxLen=4.
module tb_fp_max_reduce;
  localparam int Bits   = 32;
  localparam int MaxLen = 4;
  localparam int IW     = $clog2(MaxLen);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [Bits-1:0] in_data = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [Bits-1:0] out_max;
  logic [IW-1:0]   out_idx;
  logic [IW:0]     out_count;
  logic            out_trunc;

  int checks = 0;
  int errors = 0;

  fp_max_reduce #(.Bits(Bits), .MaxLen(MaxLen)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_idx(out_idx), .out_count(out_count), .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] data;
    int               n;
    bit               last_end;
    logic [31:0]      e_max;
    int               e_idx;
    int               e_cnt;
    bit               e_trunc;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d,
                              int n, bit le, logic [31:0] em, int ei, int ec, bit et);
    vec_t v;
    v.data[0] = a; v.data[1] = b; v.data[2] = c; v.data[3] = d;
    v.n = n; v.last_end = le; v.e_max = em; v.e_idx = ei; v.e_cnt = ec; v.e_trunc = et;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one sample over the handshake; in_ready must already be high.
  task automatic send(input logic [31:0] d, input bit last);
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = d; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] em, input int ei,
                              input int ec, input bit et);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_out_max"}, out_max, em);
    chk({tag, "_out_idx"}, 32'(out_idx), 32'(ei));
    chk({tag, "_out_count"}, 32'(out_count), 32'(ec));
    chk({tag, "_out_trunc"}, {31'd0, out_trunc}, {31'd0, et});
    $display("%s max=%h idx=%0d count=%0d trunc=%0d", tag, out_max, out_idx, out_count, out_trunc);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [31:0] held_max;

  initial begin
    vecs[0] = mk(32'h3F800000, 32'hC0000000, 32'h40400000, 32'h0, 3, 1, 32'h40400000, 2, 3, 0);
    vecs[1] = mk(32'hC0000000, 32'hBF800000, 32'hBF800000, 32'h0, 3, 1, 32'hBF800000, 2, 3, 0);
    vecs[2] = mk(32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 2, 1, 32'h3F800000, 0, 2, 0);
    vecs[3] = mk(32'h80000000, 32'h00000000, 32'h0, 32'h0, 2, 1, 32'h00000000, 1, 2, 0);
    vecs[4] = mk(32'hC2C80000, 32'h0, 32'h0, 32'h0, 1, 1, 32'hC2C80000, 0, 1, 0);
    vecs[5] = mk(32'h40000000, 32'h3F800000, 32'h3F000000, 32'h0, 3, 1, 32'h40000000, 0, 3, 0);
    vecs[6] = mk(32'hBF800000, 32'hC1000000, 32'h80000000, 32'hBF000000, 4, 1, 32'h80000000, 2, 4, 0);
    vecs[7] = mk(32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40800000, 4, 0, 32'h40800000, 3, 4, 1);

    // Reset state
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_max", out_max, 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_trunc", {31'd0, out_trunc}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].data[i], vecs[v].last_end && (i == vecs[v].n - 1));
      end
      check_result($sformatf("vec%0d", v), vecs[v].e_max, vecs[v].e_idx, vecs[v].e_cnt,
                   vecs[v].e_trunc);
      drain($sformatf("vec%0d", v));
    end

    // Continuation after the cap: 8.0 opens a fresh frame, closed by a last.
    send(32'h41000000, 0);
    send(32'h3F800000, 1);
    check_result("cap_next", 32'h41000000, 0, 2, 0);

    // Backpressure: result held, new samples refused while out_ready stays low.
    held_max = out_max;
    in_valid = 1'b1; in_data = 32'h7F000000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_result($sformatf("bp%0d", c), held_max, 0, 2, 0);
    end
    in_valid = 1'b0;
    drain("bp");

    // Reset in the middle of ACCUM drops the partial frame at once.
    send(32'h40A00000, 0);
    send(32'h40C00000, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_out_count", 32'(out_count), 32'd0);
    chk("mid_rst_out_max", out_max, 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'hBF800000, 0);
    send(32'hC0000000, 1);
    check_result("post_rst", 32'hBF800000, 0, 2, 0);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
